// File: rtl/zeptron_pkg.sv
// Shared types for the zeptron fetch stage.
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

package zeptron_pkg;
    typedef enum logic [1:0] {FETCH_BOOT, FETCH_RUN, FETCH_FLUSH} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_VECTOR = `RESET_VECTOR;
    localparam logic [31:0] INSTR_NOP    = `INSTR_NOP;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/defines.sv
// Global fetch constants shared by the zeptron front end.
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; pointers carry an extra wrap bit.
module fetch_fifo
    import zeptron_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty
);
    fetch_entry_t mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Clear wins over a same-cycle push so a squashed response never lands.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem requests, response buffer and redirect squash.
module fetch_unit
    import zeptron_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d;

    fetch_entry_t  head, push_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, push, pop, req_fire;
    logic [CW:0]   in_use;
    logic [31:0]   target;

    assign target = word_align(redirect_pc);
    // Credits cover both in-flight requests and buffered entries, so the FIFO never overflows.
    assign in_use = {1'b0, out_q} + {1'b0, fifo_count};

    assign imem_req_valid = (state_q != FETCH_BOOT) && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push       = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign id_valid = !fifo_empty && !redirect_valid;
    assign pop      = id_valid && id_ready;
    assign id_instr = id_valid ? head.instr : INSTR_NOP;
    assign id_pc    = fifo_empty ? rsp_pc_q : head.pc;
    assign id_pc4   = id_pc + 32'd4;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d   = drop_q;

        if (req_fire)
            pc_d = pc_q + 32'd4;

        if (redirect_valid) begin
            pc_d     = target;
            rsp_pc_d = target;
            drop_d   = out_q - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid) begin
            if (drop_q != '0)
                drop_d = drop_q - CW'(1);
            else
                rsp_pc_d = rsp_pc_q + 32'd4;
        end

        unique case (state_q)
            FETCH_BOOT:  state_d = FETCH_RUN;
            FETCH_RUN:   if (redirect_valid && drop_d != '0) state_d = FETCH_FLUSH;
            FETCH_FLUSH: if (!redirect_valid && drop_d == '0) state_d = FETCH_RUN;
            default:     state_d = FETCH_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH_BOOT;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .clear      (redirect_valid),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order instruction memory model.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b1;
    logic [31:0] id_instr, id_pc, id_pc4;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
    );

    int n_checks = 0;
    int n_pass = 0;
    int lat = 1;
    int cyc = 0;

    typedef struct { logic [31:0] addr; int t; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] pc4; } got_t;
    mreq_t       mq[$];
    logic [31:0] req_log[$];
    got_t        got[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A00_0003;
    endfunction

    // Memory model and decode-side monitor, sampled on the active edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            cyc++;
            if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc});
                req_log.push_back(imem_req_addr);
            end
            if (id_valid && id_ready) got.push_back('{id_pc, id_instr, id_pc4});
        end
    end

    always @(negedge clk) begin
        if (!rst && mq.size() > 0 && (cyc - mq[0].t) >= lat - 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic do_reset(input int l);
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; id_ready = 1'b1; lat = l;
        repeat (2) @(negedge clk);
        req_log.delete(); got.delete();
        rst = 1'b0;
    endtask

    task automatic wait_got(input int n, input string name);
        for (int k = 0; k < 80 && got.size() < n; k++) @(negedge clk);
        n_checks++;
        if (got.size() < n) $display("FAIL %s: timeout, got %0d handoffs, need %0d", name, got.size(), n);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (id_instr !== NOP) $display("FAIL rst_id_instr: got %h want %h", id_instr, NOP); else n_pass++;
        n_checks++; if (id_pc !== 32'h0) $display("FAIL rst_id_pc: got %h want 0", id_pc); else n_pass++;
        n_checks++; if (id_pc4 !== 32'h4) $display("FAIL rst_id_pc4: got %h want 4", id_pc4); else n_pass++;
    endtask

    task automatic test_stream();
        int bad;
        do_reset(1);
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL boot_no_req: got %b want 0", imem_req_valid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("FAIL c1_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) $display("FAIL c2_req: got v=%b a=%h want v=1 a=4", imem_req_valid, imem_req_addr); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL c2_id_valid: got %b want 0", id_valid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0) || id_pc4 !== 32'h4)
            $display("FAIL c3_first_id: got v=%b pc=%h i=%h pc4=%h want v=1 pc=0 i=%h pc4=4", id_valid, id_pc, id_instr, id_pc4, instr_of(32'h0));
        else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL c3_credit_block: got %b want 0", imem_req_valid); else n_pass++;
        repeat (12) @(negedge clk);
        wait_got(4, "stream_count");
        bad = 0;
        foreach (got[i]) if (got[i].pc !== 32'(4*i) || got[i].instr !== instr_of(32'(4*i)) || got[i].pc4 !== 32'(4*i+4)) bad++;
        n_checks++; if (bad != 0) $display("FAIL stream_pairing: got %0d bad entries want 0", bad); else n_pass++;
        bad = 0;
        foreach (req_log[i]) if (req_log[i] !== 32'(4*i)) bad++;
        n_checks++; if (bad != 0) $display("FAIL stream_addrs: got %0d bad addrs want 0", bad); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] snap_pc, snap_instr;
        int bad;
        do_reset(1);
        repeat (3) @(negedge clk);
        id_ready = 1'b0;
        #1;
        snap_pc = id_pc; snap_instr = id_instr;
        n_checks++; if (id_valid !== 1'b1 || snap_pc !== 32'h0) $display("FAIL stall_start: got v=%b pc=%h want v=1 pc=0", id_valid, snap_pc); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_checks++; if (id_valid !== 1'b1 || id_pc !== snap_pc || id_instr !== snap_instr)
                $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, id_valid, id_pc, id_instr, snap_pc, snap_instr);
            else n_pass++;
            n_checks++; if (req_log.size() - got.size() > 2) $display("FAIL stall_credit%0d: got %0d in use want <=2", k, req_log.size() - got.size()); else n_pass++;
        end
        id_ready = 1'b1;
        repeat (15) @(negedge clk);
        wait_got(5, "stall_release");
        bad = 0;
        foreach (got[i]) if (got[i].pc !== 32'(4*i) || got[i].instr !== instr_of(32'(4*i))) bad++;
        n_checks++; if (bad != 0) $display("FAIL stall_no_loss_dup: got %0d bad entries want 0", bad); else n_pass++;
    endtask

    task automatic test_redirect();
        int idx;
        do_reset(3);
        repeat (3) @(negedge clk);
        n_checks++; if (req_log.size() != 2) $display("FAIL redir_inflight: got %0d want 2", req_log.size()); else n_pass++;
        idx = req_log.size();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) $display("FAIL redir_cycle: got req=%b id=%b want 0 0", imem_req_valid, id_valid); else n_pass++;
        @(negedge clk); redirect_valid = 1'b0;
        wait_got(2, "redir_handoff");
        n_checks++; if (req_log[idx] !== 32'h100) $display("FAIL redir_req_addr: got %h want 100", req_log[idx]); else n_pass++;
        n_checks++; if (got[0].pc !== 32'h100 || got[0].instr !== instr_of(32'h100)) $display("FAIL redir_first_id: got pc=%h i=%h want pc=100 i=%h", got[0].pc, got[0].instr, instr_of(32'h100)); else n_pass++;
        n_checks++; if (got[1].pc !== 32'h104) $display("FAIL redir_second_id: got %h want 104", got[1].pc); else n_pass++;
    endtask

    task automatic test_collision();
        do_reset(1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        n_checks++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_req_valid !== 1'b0)
            $display("FAIL coll_cycle: got id=%b i=%h req=%b want 0 %h 0", id_valid, id_instr, imem_req_valid, NOP);
        else n_pass++;
        @(negedge clk); redirect_valid = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) $display("FAIL coll_next_req: got v=%b a=%h want v=1 a=40", imem_req_valid, imem_req_addr); else n_pass++;
        wait_got(1, "coll_handoff");
        n_checks++; if (got[0].pc !== 32'h40 || got[0].instr !== instr_of(32'h40)) $display("FAIL coll_first_id: got pc=%h i=%h want pc=40 i=%h", got[0].pc, got[0].instr, instr_of(32'h40)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int idx, bad;
        do_reset(3);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        idx = req_log.size();
        redirect_pc = 32'h300;
        @(negedge clk); redirect_valid = 1'b0;
        wait_got(2, "b2b_handoff");
        n_checks++; if (req_log[idx] !== 32'h300) $display("FAIL b2b_req_addr: got %h want 300", req_log[idx]); else n_pass++;
        n_checks++; if (got[0].pc !== 32'h300 || got[1].pc !== 32'h304) $display("FAIL b2b_ids: got %h %h want 300 304", got[0].pc, got[1].pc); else n_pass++;
        bad = 0;
        foreach (got[i]) if (got[i].pc < 32'h300) bad++;
        n_checks++; if (bad != 0) $display("FAIL b2b_wrong_path: got %0d stale entries want 0", bad); else n_pass++;
    endtask

    task automatic test_edges();
        int idx, g;
        do_reset(1);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        @(negedge clk); redirect_valid = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) $display("FAIL align_req: got v=%b a=%h want v=1 a=100", imem_req_valid, imem_req_addr); else n_pass++;
        wait_got(1, "align_handoff");
        n_checks++; if (got[0].pc !== 32'h100) $display("FAIL align_id_pc: got %h want 100", got[0].pc); else n_pass++;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        idx = req_log.size(); g = got.size();
        @(negedge clk); redirect_valid = 1'b0;
        repeat (10) @(negedge clk);
        wait_got(g + 2, "wrap_handoff");
        n_checks++; if (req_log[idx] !== 32'hFFFF_FFFC || req_log[idx+1] !== 32'h0) $display("FAIL wrap_req: got %h %h want fffffffc 0", req_log[idx], req_log[idx+1]); else n_pass++;
        n_checks++; if (got[g].pc !== 32'hFFFF_FFFC || got[g].pc4 !== 32'h0 || got[g+1].pc !== 32'h0)
            $display("FAIL wrap_id: got pc=%h pc4=%h next=%h want fffffffc 0 0", got[g].pc, got[g].pc4, got[g+1].pc);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || id_pc4 !== 32'h4)
            $display("FAIL mid_reset: got req=%b id=%b i=%h pc=%h pc4=%h want 0 0 %h 0 4", imem_req_valid, id_valid, id_instr, id_pc, id_pc4, NOP);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_collision();
        test_back_to_back();
        test_edges();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule
